// File: rtl/mapper_16kb_banked_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mapper_16kb_banked_pkg
// Brief    : Shared mapper types, window/decode constants and helpers.
// Revision : 1.0
// ============================================================================
package mapper_16kb_banked_pkg;

  typedef enum logic [0:0] {
    MODE_ASCII16   = 1'b0,
    MODE_GENERIC16 = 1'b1
  } mapper_mode_t;

  localparam int          c_mem_addr_w        = 27;
  localparam int          c_rom_page_shift    = 14;
  localparam int          c_sram_sel_bit      = 4;

  // cpu_addr[15:14] for the two 16KB pages of the 0x4000-0xBFFF window
  localparam logic [1:0]  c_page0_sel         = 2'b01;
  localparam logic [1:0]  c_page1_sel         = 2'b10;

  // cpu_addr[15:11] of the ASCII16 bank-register write ranges
  localparam logic [4:0]  c_ascii16_bank0_sel = 5'b01100;  // 0x6000-0x67FF
  localparam logic [4:0]  c_ascii16_bank1_sel = 5'b01110;  // 0x7000-0x77FF

  localparam logic [c_mem_addr_w-1:0] c_idle_addr = '1;
  localparam logic [7:0]              c_idle_data = 8'hFF;

  function automatic logic addr_in_window(input logic [15:0] addr);
    return (addr[15:14] == c_page0_sel) || (addr[15:14] == c_page1_sel);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mapper_16kb_banked_if.sv
`default_nettype none
// ============================================================================
// Module   : mapper_16kb_banked_if
// Brief    : CPU-side bus and translated memory request of the 16KB mapper.
// Revision : 1.0
// ============================================================================
interface mapper_16kb_banked_if
  import mapper_16kb_banked_pkg::*;
#(
  parameter int BANK_WIDTH = 8
);
  logic [15:0]             cpu_addr;
  logic [7:0]              cpu_data;
  logic                    cpu_wr;
  logic                    cpu_mreq;
  logic                    slot_cs;
  logic [c_mem_addr_w-1:0] block_base;
  logic [c_mem_addr_w-1:0] sram_base;
  logic [BANK_WIDTH-1:0]   bank_mask;
  logic                    out_ram_cs;
  logic [c_mem_addr_w-1:0] out_addr;
  logic                    out_rnw;
  logic [7:0]              out_data;

  modport master (
    output cpu_addr, cpu_data, cpu_wr, cpu_mreq, slot_cs,
           block_base, sram_base, bank_mask,
    input  out_ram_cs, out_addr, out_rnw, out_data
  );

  modport slave (
    input  cpu_addr, cpu_data, cpu_wr, cpu_mreq, slot_cs,
           block_base, sram_base, bank_mask,
    output out_ram_cs, out_addr, out_rnw, out_data
  );
endinterface
`default_nettype wire

// File: rtl/mapper_16kb_banked_wr_edge.sv
`default_nettype none
// ============================================================================
// Module   : mapper_wr_edge
// Brief    : Single-cycle pulse on the rising edge of the write strobe.
// Revision : 1.0
// ============================================================================
module mapper_wr_edge (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  output logic pulse
);

  logic r_strobe_d;

  // Clearing the history on reset makes a strobe held across release a new edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_strobe_d <= 1'b0;
    end else begin
      r_strobe_d <= strobe;
    end
  end

  assign pulse = strobe & ~r_strobe_d;

endmodule
`default_nettype wire

// File: rtl/mapper_16kb_banked.sv
`default_nettype none
// ============================================================================
// Module   : mapper_16kb_banked
// Brief    : Two-page 16KB bank mapper (ASCII16 / generic) with optional SRAM.
// Revision : 1.0
// ============================================================================
module mapper_16kb_banked
  import mapper_16kb_banked_pkg::*;
#(
  parameter mapper_mode_t MODE       = MODE_ASCII16,
  parameter int           BANK_WIDTH = 8,
  parameter bit           SRAM_EN    = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  mapper_16kb_banked_if.slave  bus
);

  localparam logic [BANK_WIDTH-1:0] c_bank1_rst =
    (MODE == MODE_GENERIC16) ? BANK_WIDTH'(1) : '0;

  logic [BANK_WIDTH-1:0]   r_bank [2];
  logic                    w_strobe;
  logic                    w_pulse;
  logic                    w_page;
  logic                    w_in_window;
  logic                    w_hit;
  logic                    w_reg_addr;
  logic                    w_ld0;
  logic                    w_ld1;
  logic                    w_sram_sel;
  logic [BANK_WIDTH-1:0]   w_wdata;
  logic [BANK_WIDTH-1:0]   w_bank_cur;
  logic [c_mem_addr_w-1:0] w_rom_off;

  assign w_strobe    = bus.slot_cs & bus.cpu_mreq & bus.cpu_wr;
  assign w_page      = bus.cpu_addr[15];
  assign w_in_window = addr_in_window(bus.cpu_addr);
  assign w_hit       = bus.slot_cs & w_in_window;
  assign w_wdata     = BANK_WIDTH'(bus.cpu_data);

  mapper_wr_edge u_wr_edge (
    .clk    (clk),
    .reset  (reset),
    .strobe (w_strobe),
    .pulse  (w_pulse)
  );

  always_comb begin
    w_reg_addr = 1'b0;
    w_ld0      = 1'b0;
    w_ld1      = 1'b0;
    if (MODE == MODE_GENERIC16) begin
      w_reg_addr = w_in_window;
      w_ld0      = w_pulse & w_in_window & ~w_page;
      w_ld1      = w_pulse & w_in_window &  w_page;
    end else begin
      w_ld0      = w_pulse & (bus.cpu_addr[15:11] == c_ascii16_bank0_sel);
      w_ld1      = w_pulse & (bus.cpu_addr[15:11] == c_ascii16_bank1_sel);
      w_reg_addr = (bus.cpu_addr[15:11] == c_ascii16_bank0_sel) ||
                   (bus.cpu_addr[15:11] == c_ascii16_bank1_sel);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bank[0] <= '0;
      r_bank[1] <= c_bank1_rst;
    end else begin
      if (w_ld0) r_bank[0] <= w_wdata;
      if (w_ld1) r_bank[1] <= w_wdata;
    end
  end

  assign w_bank_cur = w_page ? r_bank[1] : r_bank[0];
  assign w_rom_off  = c_mem_addr_w'(w_bank_cur & bus.bank_mask) << c_rom_page_shift;

  generate
    if (SRAM_EN && (MODE == MODE_ASCII16) && (BANK_WIDTH > c_sram_sel_bit)) begin : g_sram
      assign w_sram_sel = w_bank_cur[c_sram_sel_bit];
    end else begin : g_no_sram
      assign w_sram_sel = 1'b0;
    end
  endgenerate

  // Only page 1 SRAM is writable, and never on a bank-register address
  always_comb begin
    bus.out_ram_cs = 1'b0;
    bus.out_addr   = c_idle_addr;
    bus.out_rnw    = 1'b1;
    bus.out_data   = c_idle_data;
    if (w_hit) begin
      bus.out_ram_cs = 1'b1;
      if (w_sram_sel) begin
        bus.out_addr = bus.sram_base + c_mem_addr_w'(bus.cpu_addr[10:0]);
        if (w_page && w_strobe && !w_reg_addr) begin
          bus.out_rnw  = 1'b0;
          bus.out_data = bus.cpu_data;
        end
      end else begin
        bus.out_addr = bus.block_base + w_rom_off + c_mem_addr_w'(bus.cpu_addr[13:0]);
      end
    end
  end

endmodule
`default_nettype wire
